// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus for seq_divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;

  // Requester side: drives operands and start, observes status and results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// 2*WIDTH-bit dividend / WIDTH-bit divisor -> 2*WIDTH-bit quotient, WIDTH-bit remainder.
// Optional macro DIV_ZERO_CHECK_EN: a zero divisor short-circuits IDLE->DONE and
// raises div_by_zero; otherwise div_by_zero stays 0 and zero runs the full loop.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int unsigned QW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZERO_CHECK = 1'b1;
`else
  localparam bit ZERO_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [QW-1:0]     q_q, q_d;
  logic [WIDTH-1:0]  d_q, d_d;
  // Partial remainder is always < divisor between iterations, so its
  // extra (WIDTH+1)th bit is zero and only the low WIDTH bits are stored.
  logic [WIDTH-1:0]  r_q, r_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [QW-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [WIDTH:0]    trial;
  logic              fits;
  logic [WIDTH-1:0]  r_step;
  logic [QW-1:0]     q_step;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign trial  = {r_q, q_q[QW-1]};
  assign fits   = (trial >= {1'b0, d_q});
  assign r_step = fits ? WIDTH'(trial - {1'b0, d_q}) : trial[WIDTH-1:0];
  assign q_step = {q_q[QW-2:0], fits};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, iteration and result-capture logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (ZERO_CHECK && (bus.divisor == '0)) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend[WIDTH-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = BUSY;
            q_d     = bus.dividend;
            d_d     = bus.divisor;
            r_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quo_d   = q_step;
          rem_d   = r_step;
          dbz_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8).
module tb_seq_divider;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands on a falling edge and hold start for one accepting edge.
  task automatic start_div(input logic [15:0] dvd, input logic [7:0] dvs);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Cycles (sampled on falling edges) from acceptance until done; -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got busy/done/dbz=%b required 000", {bus.busy, bus.done, bus.div_by_zero});
    end
    n_cmp++;
    if ({bus.quotient, bus.remainder} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_results: got q=%0d r=%0d required 0/0", bus.quotient, bus.remainder);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy/done=%b required 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_basic;
    int lat;
    start_div(16'd160, 8'd10);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_on_accept: got %b required 1", bus.busy);
    end
    wait_done(lat);
    n_cmp++;
    if (lat != 17) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d required 17", lat);
    end
    n_cmp++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {16'd16, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_160_10: got q=%0d r=%0d dbz=%b required 16/0/0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_bad++;
      $display("FAIL done_single_pulse: got busy/done=%b required 00", {bus.busy, bus.done});
    end
    n_cmp++;
    if (bus.quotient !== 16'd16) begin
      n_bad++;
      $display("FAIL result_hold: got q=%0d required 16", bus.quotient);
    end
  endtask

  task automatic test_vectors;
    logic [15:0] dvd [3];
    logic [7:0]  dvs [3];
    logic [15:0] eq  [3];
    logic [7:0]  er  [3];
    int lat;
    dvd = '{16'd1000, 16'd65025, 16'd65535};
    dvs = '{8'd7, 8'd255, 8'd1};
    eq  = '{16'd142, 16'd255, 16'd65535};
    er  = '{8'd6, 8'd0, 8'd0};
    for (int k = 0; k < 3; k++) begin
      start_div(dvd[k], dvs[k]);
      wait_done(lat);
      n_cmp++;
      if (lat != 17 || bus.quotient !== eq[k] || bus.remainder !== er[k]) begin
        n_bad++;
        $display("FAIL vector_%0d (%0d/%0d): got lat=%0d q=%0d r=%0d required 17/%0d/%0d",
                 k, dvd[k], dvs[k], lat, bus.quotient, bus.remainder, eq[k], er[k]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    int exp_lat;
    logic exp_dbz;
`ifdef DIV_ZERO_CHECK_EN
    exp_lat = 1;
    exp_dbz = 1'b1;
`else
    exp_lat = 17;
    exp_dbz = 1'b0;
`endif
    start_div(16'd200, 8'd0);
    wait_done(lat);
    n_cmp++;
    if (lat != exp_lat) begin
      n_bad++;
      $display("FAIL div0_latency: got %0d required %0d", lat, exp_lat);
    end
    n_cmp++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {16'hFFFF, 8'd200, exp_dbz}) begin
      n_bad++;
      $display("FAIL div0_result: got q=%0d r=%0d dbz=%b required 65535/200/%b",
               bus.quotient, bus.remainder, bus.div_by_zero, exp_dbz);
    end
  endtask

  task automatic test_start_ignored;
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    start_div(16'd160, 8'd10);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 4) begin
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
    end
    n_cmp++;
    if (pulses != 1 || first != 17) begin
      n_bad++;
      $display("FAIL start_ignored_pulses: got %0d pulses first at %0d required 1 at 17", pulses, first);
    end
    n_cmp++;
    if ({bus.quotient, bus.remainder} !== {16'd16, 8'd0}) begin
      n_bad++;
      $display("FAIL start_ignored_result: got q=%0d r=%0d required 16/0", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_operand_change;
    int lat;
    start_div(16'd1000, 8'd7);
    bus.dividend = 16'd60000;
    bus.divisor  = 8'd3;
    wait_done(lat);
    n_cmp++;
    if (lat != 17 || bus.quotient !== 16'd142 || bus.remainder !== 8'd6) begin
      n_bad++;
      $display("FAIL operand_capture: got lat=%0d q=%0d r=%0d required 17/142/6", lat, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    int lat;
    pulses = 0;
    start_div(16'd160, 8'd10);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 27'h0) begin
      n_bad++;
      $display("FAIL reset_mid_clear: got busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_done: got %0d pulses required 0", pulses);
    end
    start_div(16'd30, 8'd4);
    wait_done(lat);
    n_cmp++;
    if (lat != 17 || bus.quotient !== 16'd7 || bus.remainder !== 8'd2) begin
      n_bad++;
      $display("FAIL after_reset_30_4: got lat=%0d q=%0d r=%0d required 17/7/2", lat, bus.quotient, bus.remainder);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_start_ignored();
    test_operand_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
